multicycle_controller: RTL
==========================

# multicycle_controller

Control finite-state machine (FSM) for the multicycle datapath. It sequences instruction fetch, decode, execute, memory access and write-back. It drives the ALU function code and the datapath register, memory and program-counter (PC) enables, and consumes the ALU `zero` flag to resolve branches. It sits beside the ALU as the issuer of `func` codes and the consumer of `zero`.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of cycles to wait for `mem_ready` before raising `bus_error`.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  4  instruction register bits [15:12], valid from DECODE onward.
- `zero`  in  1  ALU compare flag: 0 when ri == rj, 1 when they differ.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `alu_func`  out  3  000 pass ri, 001 add, 010 sub, 011 and, 100 or, 101 not rj.
- `ir_write`  out  1  load instruction register.
- `pc_write`  out  1  update PC.
- `pc_src`  out  2  00 PC+1, 01 branch target, 10 jump target.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `mem_addr_src`  out  1  0 = PC, 1 = ALU result.
- `reg_write`  out  1  register-file write.
- `reg_src`  out  1  0 = ALU result, 1 = memory data.
- `halted`  out  1  FSM is in HALT.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `bus_error`  out  1  sticky; set on memory timeout, cleared only by reset.

## Operation
- States: FETCH, DECODE, EXEC, WB, MEM_RD, MEM_WR, BRANCH, HALT.
- Opcodes:
  - 0000 MOV, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 NOT map to `alu_func` 000 through 101.
  - 1000 LOAD, 1001 STORE, 1100 BEQ, 1101 JMP, 1111 HALT.
  - All other opcodes are illegal.
- FETCH:
  - `mem_read=1`, `mem_addr_src=0`.
  - On `mem_ready`: `ir_write=1`, `pc_write=1`, `pc_src=00`, then go to DECODE.
- DECODE:
  - ALU ops go to EXEC; LOAD and STORE go to EXEC with `alu_func=001` (address add).
  - BEQ goes to BRANCH.
  - JMP: `pc_write=1`, `pc_src=10`, then FETCH.
  - HALT goes to HALT.
  - Illegal: pulse `illegal`, then FETCH (treated as NOP).
- EXEC:
  - `alu_func` is held from the opcode.
  - Next state: WB for ALU ops, MEM_RD for LOAD, MEM_WR for STORE.
- WB: `reg_write=1`, `reg_src=0`, then FETCH.
- MEM_RD:
  - `mem_read=1`, `mem_addr_src=1`.
  - On `mem_ready`: `reg_write=1`, `reg_src=1`, then FETCH.
- MEM_WR:
  - `mem_write=1`, `mem_addr_src=1`.
  - On `mem_ready`, go to FETCH.
- BRANCH:
  - `alu_func=010`.
  - If `zero==0`: `pc_write=1`, `pc_src=01`.
  - Always go to FETCH next.
- HALT: absorbing; all strobes are 0 and `halted=1`. Only `rst` exits.
- Timeout counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle the FSM waits with `mem_ready=0`.
  - On reaching `MEM_TIMEOUT`: set `bus_error`, deassert strobes, go to HALT.
  - Counter width is ceil(log2(MEM_TIMEOUT+1)).

## Timing
- Reset (asynchronous, immediate):
  - State goes to FETCH and the counter to 0.
  - `bus_error=0`, `halted=0`, `illegal=0`.
  - Strobes then decode from FETCH, so `mem_read=1` in the first cycle after reset.
- Output decoding:
  - Outputs are decoded combinationally from registered state; no output flops.
  - `ir_write`, FETCH's `pc_write`, MEM_RD's `reg_write` and the FETCH/MEM_RD/MEM_WR exits are additionally qualified by same-cycle `mem_ready`.
- Latency with zero-wait memory (`mem_ready` always 1):
  - ALU op: 4 cycles.
  - LOAD, STORE: 4 cycles.
  - BEQ: 3 cycles.
  - JMP: 2 cycles.
- Each wait cycle adds 1 cycle.
- `mem_ready` asserted while no memory strobe is active is ignored.
- If `mem_ready` arrives on the same cycle the counter reaches `MEM_TIMEOUT`, `mem_ready` wins: the transfer completes and there is no error.
- BRANCH samples `zero` in the BRANCH cycle only.
- Reset asserted mid-transfer aborts it; no partial `reg_write` is emitted.

## Structure
- Shared package holds:
  - opcode constants and the `alu_func` encodings;
  - the state enum;
  - the `pc_src` encodings.
- A single module; no sub-module is needed. The timeout counter stays inline.

## Test plan
- ADD, zero-wait memory: opcode 0001 after reset → states FETCH, DECODE, EXEC, WB; `alu_func=001` in EXEC; `reg_write=1` on cycle 4, `reg_src=0`.
- LOAD with 3 wait cycles: `mem_ready` low for 3 cycles in MEM_RD → `mem_read` held 4 cycles; `reg_write=1`, `reg_src=1` on the 4th; total 7 cycles.
- BEQ taken/not taken: `zero=0` → `pc_write=1`, `pc_src=01`; `zero=1` → `pc_write=0`; both return to FETCH.
- Timeout: `MEM_TIMEOUT=4`, `mem_ready` held 0 in FETCH → after 4 cycles `bus_error=1`, `halted=1`; stays there until `rst`.
- Illegal opcode 0110 → `illegal` pulses 1 cycle in DECODE; next state FETCH; no `reg_write`.
- HALT then reset: opcode 1111 → `halted` held. Asserting `rst` mid-cycle immediately returns to FETCH, with `mem_read=1` and `bus_error=0`.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - opcode, ALU function, PC source and state definitions
package multicycle_controller_pkg;

    localparam logic [3:0] OP_MOV   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_NOT  = 3'b101;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_BRANCH,
        ST_HALT
    } state_t;

    // ALU opcodes carry their alu_func encoding in the low three bits.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0) && (op[2:0] <= ALU_NOT);
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing fetch/decode/execute/memory/write-back
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic [2:0] o_alu_func,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic [1:0] o_pc_src,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_mem_addr_src,
    output logic       o_reg_write,
    output logic       o_reg_src,
    output logic       o_halted,
    output logic       o_illegal,
    output logic       o_bus_error
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_bus_error;
    logic          w_waiting;
    logic          w_timeout;

    assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR))
                       && !i_mem_ready;
    // The waiting cycle that would bring the counter to MEM_TIMEOUT is the last one allowed.
    assign w_timeout = w_waiting && (r_cnt == CNT_LAST);
    assign o_bus_error = r_bus_error;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_FETCH;
            r_cnt       <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        o_alu_func     = ALU_PASS;
        o_ir_write     = 1'b0;
        o_pc_write     = 1'b0;
        o_pc_src       = PC_SRC_INC;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_mem_addr_src = 1'b0;
        o_reg_write    = 1'b0;
        o_reg_src      = 1'b0;
        o_halted       = 1'b0;
        o_illegal      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_mem_read = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (is_alu_op(i_opcode)) begin
                    o_alu_func = i_opcode[2:0];
                    w_next     = ST_EXEC;
                end else begin
                    case (i_opcode)
                        OP_LOAD, OP_STORE: begin
                            o_alu_func = ALU_ADD;
                            w_next     = ST_EXEC;
                        end
                        OP_BEQ:  w_next = ST_BRANCH;
                        OP_JMP: begin
                            o_pc_write = 1'b1;
                            o_pc_src   = PC_SRC_JUMP;
                            w_next     = ST_FETCH;
                        end
                        OP_HALT: w_next = ST_HALT;
                        default: begin
                            o_illegal = 1'b1;
                            w_next    = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                if (is_alu_op(i_opcode)) begin
                    o_alu_func = i_opcode[2:0];
                    w_next     = ST_WB;
                end else if (i_opcode == OP_LOAD) begin
                    o_alu_func = ALU_ADD;
                    w_next     = ST_MEM_RD;
                end else if (i_opcode == OP_STORE) begin
                    o_alu_func = ALU_ADD;
                    w_next     = ST_MEM_WR;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_WB: begin
                o_reg_write = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_MEM_RD: begin
                o_mem_read     = 1'b1;
                o_mem_addr_src = 1'b1;
                if (i_mem_ready) begin
                    o_reg_write = 1'b1;
                    o_reg_src   = 1'b1;
                    w_next      = ST_FETCH;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_MEM_WR: begin
                o_mem_write    = 1'b1;
                o_mem_addr_src = 1'b1;
                if (i_mem_ready) begin
                    w_next = ST_FETCH;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_BRANCH: begin
                o_alu_func = ALU_SUB;
                if (!i_zero) begin
                    o_pc_write = 1'b1;
                    o_pc_src   = PC_SRC_BRANCH;
                end
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                o_halted = 1'b1;
            end
            default: w_next = ST_FETCH;
        endcase
    end

endmodule
